// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin grant arbiters.
package rr_arb_pkg;

  localparam int DEFAULT_MAX_HOLD = 4;
  localparam int MAX_N            = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // One-hot vector with bit idx set; all-zero when idx is not below n.
  function automatic logic [MAX_N-1:0] onehot(input int unsigned idx, input int unsigned n);
    return (idx < n) ? (MAX_N'(1) << idx) : '0;
  endfunction

endpackage

// File: rtl/rr_grant_arbiter_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping mod N.
module rr_pick #(
  parameter  int N   = 4,
  localparam int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic           any,
  output logic [IDW-1:0] sel_idx
);

  logic [N-1:0]   rot;
  logic [IDW-1:0] off;
  logic [IDW:0]   sum;

  // NOTE: every variable written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    rot = N'({req, req} >> ptr);
    any = |rot;
    off = '0;
    // Descending scan so the lowest set bit (closest to ptr) wins.
    for (int j = N - 1; j >= 0; j--) begin
      if (rot[j]) off = IDW'(j);
    end
    sum = {1'b0, off} + {1'b0, ptr};
    if (sum >= (IDW + 1)'(N)) sum = sum - (IDW + 1)'(N);
    sel_idx = sum[IDW-1:0];
  end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter with registered one-hot grant, fairness pointer and bounded hold.
module rr_grant_arbiter
  import rr_arb_pkg::*;
#(
  parameter  int N        = 4,
  parameter  int MAX_HOLD = DEFAULT_MAX_HOLD,
  localparam int IDW      = $clog2(N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           busy
);

  localparam int             HW        = $clog2(MAX_HOLD) + 1;
  localparam logic [HW-1:0]  HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [IDW-1:0] LAST_IDX  = IDW'(N - 1);

  state_t         state;
  logic [IDW-1:0] owner;
  logic [IDW-1:0] ptr;
  logic [HW-1:0]  hold_cnt;

  logic           pick_any;
  logic [IDW-1:0] pick_idx;
  logic           others;
  logic           give_up;
  logic [IDW-1:0] ptr_after;

  rr_pick #(.N(N)) u_pick (
    .req     (req),
    .ptr     (ptr),
    .any     (pick_any),
    .sel_idx (pick_idx)
  );

  // In GRANT, gnt is exactly onehot(owner), so masking with it isolates competitors.
  assign others    = |(req & ~gnt);
  assign give_up   = !req[owner] || (hold_cnt == HOLD_LAST && others);
  assign ptr_after = (owner == LAST_IDX) ? '0 : owner + 1'b1;

  assign gnt_id = owner;
  assign busy   = |gnt;

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values; reset is synchronous, checked only at the clock edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      gnt      <= '0;
      owner    <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            state    <= ST_GRANT;
            owner    <= pick_idx;
            gnt      <= N'(onehot(32'(pick_idx), N));
            hold_cnt <= '0;
          end
        end
        ST_GRANT: begin
          if (give_up) begin
            // Ownership changes always pass through one dead IDLE cycle.
            state <= ST_IDLE;
            gnt   <= '0;
            ptr   <= ptr_after;
          end else if (hold_cnt != HOLD_LAST) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          gnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Self-checking bench for rr_grant_arbiter: directed scenarios plus randomized run vs a reference model.
module tb_rr_grant_arbiter;

  localparam int N        = 4;
  localparam int MAX_HOLD = 4;
  localparam int IDW      = $clog2(N);

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic           busy;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model: owner (-1 = nobody), priority start, consecutive grant cycles, last owner.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_run   = 0;
  int m_last  = 0;

  rr_grant_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic model_edge(input logic [N-1:0] r, input logic rst);
    int others;
    if (rst) begin
      m_owner = -1; m_ptr = 0; m_run = 0; m_last = 0;
    end else if (m_owner < 0) begin
      for (int i = 0; i < N; i++) begin
        int idx;
        idx = (m_ptr + i) % N;
        if (r[idx] && m_owner < 0) begin
          m_owner = idx; m_run = 1; m_last = idx;
        end
      end
    end else begin
      others = 0;
      for (int i = 0; i < N; i++) if (i != m_owner && r[i]) others++;
      if (!r[m_owner] || (m_run >= MAX_HOLD && others > 0)) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end else begin
        m_run++;
      end
    end
  endtask

  function automatic logic [N-1:0] model_gnt();
    return (m_owner < 0) ? '0 : (N'(1) << m_owner);
  endfunction

  // Drive req for one edge, then settle 1 time unit past the edge before sampling.
  task automatic cyc(input logic [N-1:0] r);
    req = r;
    @(posedge clk);
    model_edge(r, reset);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc('0);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc(4'b1111);
    cyc(4'b1111);
    total_cnt++;
    if (gnt !== 4'b0000) $display("FAIL reset_gnt got=%b want=0000", gnt); else pass_cnt++;
    total_cnt++;
    if (gnt_id !== 2'd0) $display("FAIL reset_gnt_id got=%0d want=0", gnt_id); else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy); else pass_cnt++;
    reset = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      cyc(4'b0001);
      total_cnt++;
      if (gnt !== 4'b0001 || gnt_id !== 2'd0 || busy !== 1'b1)
        $display("FAIL basic_grant c=%0d got gnt=%b id=%0d busy=%b want 0001/0/1", c, gnt, gnt_id, busy);
      else pass_cnt++;
    end
    cyc(4'b0000);
    total_cnt++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || gnt_id !== 2'd0)
      $display("FAIL basic_release got gnt=%b busy=%b id=%0d want 0000/0/0", gnt, busy, gnt_id);
    else pass_cnt++;
  endtask

  task automatic test_contention();
    logic [N-1:0] exp;
    do_reset();
    for (int c = 0; c < 22; c++) begin
      cyc(4'b1111);
      exp = ((c % 5) < 4) ? (N'(1) << ((c / 5) % N)) : '0;
      total_cnt++;
      if (gnt !== exp) $display("FAIL contention c=%0d got=%b want=%b", c, gnt, exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_sole_holder();
    int bad;
    do_reset();
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      cyc(4'b0100);
      if (gnt !== 4'b0100) bad++;
    end
    total_cnt++;
    if (bad != 0) $display("FAIL sole_hold got %0d cycles not 0100 want 0", bad); else pass_cnt++;
    cyc(4'b0101);
    total_cnt++;
    if (gnt !== 4'b0000) $display("FAIL sole_yield got=%b want=0000", gnt); else pass_cnt++;
    cyc(4'b0101);
    total_cnt++;
    if (gnt !== 4'b0001 || gnt_id !== 2'd0)
      $display("FAIL sole_regrant got gnt=%b id=%0d want 0001/0", gnt, gnt_id);
    else pass_cnt++;
  endtask

  task automatic test_early_release();
    do_reset();
    cyc(4'b0101);
    cyc(4'b0101);
    total_cnt++;
    if (gnt !== 4'b0001) $display("FAIL early_owner got=%b want=0001", gnt); else pass_cnt++;
    cyc(4'b0100);
    total_cnt++;
    if (gnt !== 4'b0000) $display("FAIL early_dead got=%b want=0000", gnt); else pass_cnt++;
    cyc(4'b0101);
    total_cnt++;
    if (gnt !== 4'b0100 || gnt_id !== 2'd2)
      $display("FAIL early_next got gnt=%b id=%0d want 0100/2", gnt, gnt_id);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    do_reset();
    cyc(4'b0100);
    cyc(4'b1001);
    total_cnt++;
    if (gnt !== 4'b0000 || gnt_id !== 2'd2)
      $display("FAIL wrap_release got gnt=%b id=%0d want 0000/2", gnt, gnt_id);
    else pass_cnt++;
    cyc(4'b1001);
    total_cnt++;
    if (gnt !== 4'b1000 || gnt_id !== 2'd3)
      $display("FAIL wrap_first got gnt=%b id=%0d want 1000/3", gnt, gnt_id);
    else pass_cnt++;
    cyc(4'b0001);
    total_cnt++;
    if (gnt !== 4'b0000 || gnt_id !== 2'd3)
      $display("FAIL wrap_hold_id got gnt=%b id=%0d want 0000/3", gnt, gnt_id);
    else pass_cnt++;
    cyc(4'b0011);
    total_cnt++;
    if (gnt !== 4'b0001 || gnt_id !== 2'd0)
      $display("FAIL wrap_second got gnt=%b id=%0d want 0001/0", gnt, gnt_id);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    cyc(4'b1001);
    cyc(4'b0010);
    cyc(4'b0010);
    total_cnt++;
    if (gnt !== 4'b0010) $display("FAIL mid_setup got=%b want=0010", gnt); else pass_cnt++;
    reset = 1'b1;
    cyc(4'b0010);
    reset = 1'b0;
    total_cnt++;
    if (gnt !== 4'b0000 || gnt_id !== 2'd0)
      $display("FAIL mid_reset got gnt=%b id=%0d want 0000/0", gnt, gnt_id);
    else pass_cnt++;
    cyc(4'b1111);
    total_cnt++;
    if (gnt !== 4'b0001) $display("FAIL mid_ptr got=%b want=0001", gnt); else pass_cnt++;
  endtask

  task automatic test_random();
    logic [N-1:0] r;
    logic [N-1:0] exp;
    do_reset();
    r = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < N; b++) if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
      if (c % 500 == 250) reset = 1'b1;
      cyc(r);
      reset = 1'b0;
      exp = model_gnt();
      total_cnt++;
      if (gnt !== exp || gnt_id !== IDW'(m_last) || busy !== (m_owner >= 0))
        $display("FAIL random c=%0d req=%b got gnt=%b id=%0d busy=%b want gnt=%b id=%0d busy=%b",
                 c, r, gnt, gnt_id, busy, exp, m_last, (m_owner >= 0));
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_contention();
    test_sole_holder();
    test_early_release();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
